pipe_exmem_hs: RTL

PIPE_EXMEM_HS -- requirements
Module: pipe_exmem_hs

---
 rtl/pipe_exmem_hs.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_exmem_hs.sv
// EX/MEM pipeline register with valid/ready handshake on both sides.
// Latency: one cycle from transfer-in to out_valid (skid adds no extra latency).
// Backpressure: out_ready=0 holds the output; with PIPE_EXMEM_SKID_EN one extra
//   instruction is parked and in_ready drops (registered), otherwise in_ready
//   follows !out_valid | out_ready combinationally.
//
// Optional feature macro: PIPE_EXMEM_SKID_EN (one-entry skid buffer).
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   flush               kills the held, parked and incoming instruction
//   in_valid/in_ready   upstream handshake from EX
//   pc_i .. opcode_i    EX payload (pc, store data, ALU result, control)
//   out_valid/out_ready downstream handshake to MEM
//   pc_o .. opcode_o    registered payload towards MEM
//   stall_cnt           saturating count of cycles with out_valid=1, out_ready=0
module pipe_exmem_hs #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic            rd_wren_i,
  input  logic            mem_wren_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [2:0]      imm_sel_i,
  input  logic [2:0]      imm_sto_i,
  input  logic [4:0]      opcode_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] data2_o,
  output logic [XLEN-1:0] alu_data_o,
  output logic [RA_W-1:0] rd_o,
  output logic            rd_wren_o,
  output logic            mem_wren_o,
  output logic [1:0]      wb_sel_o,
  output logic [2:0]      imm_sel_o,
  output logic [2:0]      imm_sto_o,
  output logic [4:0]      opcode_o,
  output logic [31:0]     stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] alu;
    logic [RA_W-1:0] rd;
    logic            rd_wren;
    logic            mem_wren;
    logic [1:0]      wb_sel;
    logic [2:0]      imm_sel;
    logic [2:0]      imm_sto;
    logic [4:0]      opcode;
  } exmem_t;

  exmem_t in_dat;
  exmem_t out_q;
  logic   xfer_in;
  logic   xfer_out;

  always_comb begin
    in_dat          = '0;
    in_dat.pc       = pc_i;
    in_dat.data2    = data2_i;
    in_dat.alu      = alu_data_i;
    in_dat.rd       = rd_i;
    in_dat.rd_wren  = rd_wren_i;
    in_dat.mem_wren = mem_wren_i;
    in_dat.wb_sel   = wb_sel_i;
    in_dat.imm_sel  = imm_sel_i;
    in_dat.imm_sto  = imm_sto_i;
    in_dat.opcode   = opcode_i;
  end

  // flush overrides any incoming instruction
  assign xfer_in  = in_valid && in_ready && !flush;
  // a transfer-out on a flush cycle still completes for the consumer
  assign xfer_out = out_valid && out_ready;

`ifdef PIPE_EXMEM_SKID_EN
  exmem_t skid_q;
  logic   skid_vld;
  logic   load_out;
  logic   park;

  // in_ready is purely the registered "skid empty" flag
  assign in_ready = !skid_vld;
  // skid_vld implies in_ready=0, so xfer_in never coincides with a full skid
  assign load_out = xfer_in && (!out_valid || out_ready);
  assign park     = xfer_in && out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_vld  <= 1'b0;
      skid_q    <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      out_q.rd_wren  <= 1'b0;
      out_q.mem_wren <= 1'b0;
      skid_vld       <= 1'b0;
    end else begin
      if (skid_vld && xfer_out) begin
        // parked instruction is older than anything upstream: it goes first
        out_valid <= 1'b1;
        out_q     <= skid_q;
        skid_vld  <= 1'b0;
      end else if (load_out) begin
        out_valid <= 1'b1;
        out_q     <= in_dat;
      end else if (xfer_out) begin
        out_valid      <= 1'b0;
        out_q.rd_wren  <= 1'b0;
        out_q.mem_wren <= 1'b0;
      end
      if (park) begin
        skid_vld <= 1'b1;
        skid_q   <= in_dat;
      end
    end
  end

  // a parked instruction always sits behind a valid output
  a_skid_behind_out: assert property (@(posedge clk) disable iff (rst)
    skid_vld |-> out_valid);
`else
  // no storage beyond the output register: accept only if it empties now
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      out_q.rd_wren  <= 1'b0;
      out_q.mem_wren <= 1'b0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_q     <= in_dat;
    end else if (xfer_out) begin
      out_valid      <= 1'b0;
      out_q.rd_wren  <= 1'b0;
      out_q.mem_wren <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign pc_o       = out_q.pc;
  assign data2_o    = out_q.data2;
  assign alu_data_o = out_q.alu;
  assign rd_o       = out_q.rd;
  assign rd_wren_o  = out_q.rd_wren;
  assign mem_wren_o = out_q.mem_wren;
  assign wb_sel_o   = out_q.wb_sel;
  assign imm_sel_o  = out_q.imm_sel;
  assign imm_sto_o  = out_q.imm_sto;
  assign opcode_o   = out_q.opcode;

  // write enables never leak out of an empty stage
  a_no_wren_bubble: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> !(rd_wren_o || mem_wren_o));

  // a stalled output is frozen until the consumer takes it or a flush kills it
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_q)));

endmodule
